// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared select width, register-file select code and entry layout
package fwd_pkg;

  localparam int FWD_SEL_RF = 0;

  // Entry record packed as {rem, addr, valid}; widths follow the top-level parameters.
  localparam int ENT_VALID_BIT = 0;
  localparam int ENT_ADDR_LSB  = 1;

  function automatic int selW(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int entRemLsb(input int addrW);
    return 1 + addrW;
  endfunction

  function automatic int entryW(input int addrW, input int latW);
    return 1 + addrW + latW;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - youngest-producer match for one source operand
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2
) (
  input  logic [DEPTH-1:0]        entValid,
  input  logic [DEPTH*ADDR_W-1:0] entAddr,
  input  logic [DEPTH-1:0]        entReady,
  input  logic [ADDR_W-1:0]       srcAddr,
  output logic [SEL_W-1:0]        sel,
  output logic                    busy
);

  logic hit;

  // The first hit (youngest stage) decides; an older ready copy never overrides it.
  always_comb begin
    sel  = SEL_W'(FWD_SEL_RF);
    busy = 1'b0;
    hit  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!hit && entValid[k] && (srcAddr != '0) &&
          (entAddr[k*ADDR_W +: ADDR_W] == srcAddr)) begin
        hit = 1'b1;
        if (entReady[k]) sel = SEL_W'(k + 1);
        else             busy = 1'b1;
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// rtl/forward_scoreboard.sv - producer stage tracker with forward select and stall; FWD_STALL_CNT_EN adds stall_cnt
module forward_scoreboard
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  parameter  int DEPTH   = 3,
  parameter  int ADDR_W  = 5,
  parameter  int LAT_W   = 2,
  localparam int SEL_W   = selW(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iss_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] iss_src_addr,
  input  logic                      iss_dst_we,
  input  logic [ADDR_W-1:0]         iss_dst_addr,
  input  logic [LAT_W-1:0]          iss_lat,
  input  logic                      advance,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall
`ifdef FWD_STALL_CNT_EN
  ,output logic [31:0]              stall_cnt
`endif
);

  localparam int EW = entryW(ADDR_W, LAT_W);
  localparam int RL = entRemLsb(ADDR_W);

  logic [EW-1:0]           ent [DEPTH];
  logic [EW-1:0]           issEnt;
  logic [DEPTH-1:0]        entValid;
  logic [DEPTH-1:0]        entReady;
  logic [DEPTH*ADDR_W-1:0] entAddr;
  logic [NUM_SRC-1:0]      srcBusy;

  function automatic logic [EW-1:0] age(input logic [EW-1:0] e);
    logic [EW-1:0] r;
    r = e;
    if (e[RL +: LAT_W] != '0) r[RL +: LAT_W] = e[RL +: LAT_W] - LAT_W'(1);
    return r;
  endfunction

  always_comb begin
    entValid = '0;
    entReady = '0;
    entAddr  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      entValid[k]                  = ent[k][ENT_VALID_BIT];
      entAddr[k*ADDR_W +: ADDR_W]  = ent[k][ENT_ADDR_LSB +: ADDR_W];
      entReady[k]                  = (ent[k][RL +: LAT_W] == '0);
    end
  end

  always_comb begin
    issEnt                          = '0;
    issEnt[ENT_VALID_BIT]           = iss_valid & iss_dst_we & (iss_dst_addr != '0);
    issEnt[ENT_ADDR_LSB +: ADDR_W]  = iss_dst_addr;
    issEnt[RL +: LAT_W]             = iss_lat;
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : gMatch
    fwd_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .SEL_W  (SEL_W)
    ) uMatch (
      .entValid (entValid),
      .entAddr  (entAddr),
      .entReady (entReady),
      .srcAddr  (iss_src_addr[s*ADDR_W +: ADDR_W]),
      .sel      (fwd_sel[s*SEL_W +: SEL_W]),
      .busy     (srcBusy[s])
    );
  end

  assign stall = iss_valid & (|srcBusy);

  // A stalled or flushed issue slot enters stage 1 as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
    end else if (advance) begin
      ent[0] <= (stall || flush) ? '0 : issEnt;
      for (int k = 1; k < DEPTH; k++) ent[k] <= age(ent[k-1]);
    end else if (flush) begin
      ent[0][ENT_VALID_BIT] <= 1'b0;
    end
  end

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      stall_cnt <= '0;
    else if (stall && advance && (stall_cnt != '1))  stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb/tb_forward_scoreboard.sv - scoreboard bench for forward_scoreboard against an in-flight instruction model
module tb_forward_scoreboard;

  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;
  localparam int ADDR_W  = 5;
  localparam int LAT_W   = 2;
  localparam int SEL_W   = $clog2(DEPTH + 1);

  logic                      clk;
  logic                      rst_n;
  logic                      iss_valid;
  logic [NUM_SRC*ADDR_W-1:0] iss_src_addr;
  logic                      iss_dst_we;
  logic [ADDR_W-1:0]         iss_dst_addr;
  logic [LAT_W-1:0]          iss_lat;
  logic                      advance;
  logic                      flush;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]               stall_cnt;
`endif

  forward_scoreboard #(
    .NUM_SRC (NUM_SRC),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .LAT_W   (LAT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iss_valid    (iss_valid),
    .iss_src_addr (iss_src_addr),
    .iss_dst_we   (iss_dst_we),
    .iss_dst_addr (iss_dst_addr),
    .iss_lat      (iss_lat),
    .advance      (advance),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .stall        (stall)
`ifdef FWD_STALL_CNT_EN
    ,.stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int stage;
    int dst;
    int rem;
  } flight_t;

  typedef struct {
    logic [NUM_SRC*SEL_W-1:0] sel;
    logic                     stl;
  } exp_t;

  flight_t flight[$];
  exp_t    expQ[$];
  int      total = 0;
  int      bad   = 0;
  int      stallModel = 0;

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Youngest in-flight writer of src decides: ready -> its stage, not ready -> hazard.
  function automatic void lookup(input int src, output int sel, output bit busy);
    int best;
    best = -1;
    sel  = 0;
    busy = 0;
    if (src == 0) return;
    foreach (flight[i])
      if (flight[i].dst == src && (best < 0 || flight[i].stage < flight[best].stage)) best = i;
    if (best >= 0) begin
      if (flight[best].rem == 0) sel = flight[best].stage;
      else busy = 1;
    end
  endfunction

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic doCycle(input logic iv, input int s0, input int s1, input logic we,
                         input int dst, input int lat, input logic adv, input logic fl);
    exp_t    e;
    int      sel;
    bit      busy;
    bit      anyBusy;
    int      srcs[2];
    flight_t next[$];
    srcs[0] = s0;
    srcs[1] = s1;
    iss_valid    = iv;
    iss_src_addr = {ADDR_W'(s1), ADDR_W'(s0)};
    iss_dst_we   = we;
    iss_dst_addr = ADDR_W'(dst);
    iss_lat      = LAT_W'(lat);
    advance      = adv;
    flush        = fl;
    anyBusy = 0;
    e.sel   = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      lookup(srcs[s], sel, busy);
      e.sel[s*SEL_W +: SEL_W] = SEL_W'(sel);
      anyBusy |= busy;
    end
    e.stl = iv && anyBusy;
    expQ.push_back(e);
    @(posedge clk);
    if (adv) begin
      foreach (flight[i]) begin
        flight_t f;
        f = flight[i];
        f.stage++;
        if (f.rem > 0) f.rem--;
        if (f.stage <= DEPTH) next.push_back(f);
      end
      if (!e.stl && !fl && iv && we && dst != 0) begin
        flight_t n;
        n.stage = 1;
        n.dst   = dst;
        n.rem   = lat;
        next.push_front(n);
      end
      if (e.stl) stallModel++;
      flight = next;
    end else if (fl) begin
      foreach (flight[i]) if (flight[i].stage != 1) next.push_back(flight[i]);
      flight = next;
    end
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("fwd_sel", fwd_sel, e.sel);
        check("stall", stall, e.stl);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst_n        = 1'b0;
    iss_valid    = 1'b1;
    iss_src_addr = {ADDR_W'(3), ADDR_W'(3)};
    iss_dst_we   = 1'b0;
    iss_dst_addr = '0;
    iss_lat      = '0;
    advance      = 1'b1;
    flush        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_fwd_sel", fwd_sel, 0);
    check("reset_stall", stall, 0);
    rst_n = 1'b1;

    // ALU producer forwarded from EX
    doCycle(1, 0, 0, 1, 3, 0, 1, 0);
    doCycle(1, 3, 0, 0, 0, 0, 1, 0);
    // load-use: one stall cycle, then forwarded from stage 2
    doCycle(1, 0, 0, 1, 4, 1, 1, 0);
    doCycle(1, 0, 4, 0, 0, 0, 1, 0);
    doCycle(1, 0, 4, 0, 0, 0, 1, 0);
    // two writers of r5: youngest wins
    doCycle(1, 0, 0, 1, 5, 0, 1, 0);
    doCycle(1, 0, 0, 1, 5, 0, 1, 0);
    doCycle(1, 5, 0, 0, 0, 0, 1, 0);
    // r0 never forwards
    doCycle(1, 0, 0, 1, 0, 0, 1, 0);
    doCycle(1, 0, 0, 0, 0, 0, 1, 0);
    // frozen load in stage 1, then flush while frozen
    doCycle(1, 0, 0, 1, 6, 1, 1, 0);
    repeat (3) doCycle(1, 6, 0, 0, 0, 0, 0, 0);
    doCycle(1, 6, 0, 0, 0, 0, 0, 1);
    doCycle(1, 6, 0, 0, 0, 0, 0, 0);
    doCycle(1, 6, 0, 0, 0, 0, 1, 0);
    // no issue: no stall even with a pending load
    doCycle(1, 0, 0, 1, 7, 3, 1, 0);
    doCycle(0, 7, 7, 0, 0, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      doCycle($urandom_range(0, 9) != 0,
              $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 3) != 0, $urandom_range(0, 7),
              $urandom_range(0, 3),
              $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
    end

    @(negedge clk);
`ifdef FWD_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stallModel);
`endif

    // reset in mid-stall
    @(posedge clk);
    #1;
    doCycle(1, 0, 0, 1, 6, 2, 1, 0);
    iss_valid    = 1'b1;
    iss_src_addr = {ADDR_W'(0), ADDR_W'(6)};
    iss_dst_we   = 1'b0;
    advance      = 1'b1;
    flush        = 1'b0;
    #1;
    check("midstall_stall", stall, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_stall", stall, 0);
    check("async_reset_fwd_sel", fwd_sel, 0);
`ifdef FWD_STALL_CNT_EN
    check("async_reset_stall_cnt", stall_cnt, 0);
`endif
    @(negedge clk);
    check("drain", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
